// File: rtl/seq_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// seq_det_pkg -- state encoding shared by the serial pattern detector.
// Revision: 1.0
// ============================================================================
package seq_det_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_pattern_detector_if.sv
`default_nettype none
// ============================================================================
// seq_pattern_detector_if -- control, serial data and status bundle.
// Revision: 1.0
// ============================================================================
interface seq_pattern_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;

  logic                LoadPat;
  logic [PAT_W-1:0]    PatIn;
  logic                Overlap;
  logic                w_valid;
  logic                w;
  logic                z;
  logic [CNT_W-1:0]    MatchCount;
  logic                CountSat;
  logic [STATE_W-1:0]  CurState;

  modport master (
    output LoadPat, PatIn, Overlap, w_valid, w,
    input  z, MatchCount, CountSat, CurState
  );

  modport slave (
    input  LoadPat, PatIn, Overlap, w_valid, w,
    output z, MatchCount, CountSat, CurState
  );

endinterface
`default_nettype wire

// File: rtl/seq_pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter -- saturating match counter with sticky all-ones flag.
// Revision: 1.0
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             sat_q;
  logic             sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      // Flag rises in the same cycle the count first reads all-ones.
      if (count_d == CNT_MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// seq_pattern_detector -- runtime-loadable serial pattern detector with
// qualified input, overlap control and saturating match count.
// Revision: 1.0
// ============================================================================
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  seq_pattern_detector_if.slave bus
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_e            state_q;
  state_e            state_d;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  pat_d;
  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic              z_q;
  logic              z_d;
  logic              accept;
  logic              match;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bus.w};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    accept     = bus.w_valid && (state_q != ST_IDLE) && !bus.LoadPat;
    match      = accept && (hist_shift == pat_q) && (fill_inc == FILL_FULL);

    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    z_d     = match;

    if (bus.LoadPat) begin
      // Load overrides any concurrent data bit.
      pat_d   = bus.PatIn;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (accept) begin
      if (match && !bus.Overlap) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        hist_d  = hist_shift;
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_FULL) ? ST_SEARCH : ST_FILL;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      z_q     <= z_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (match),
    .clear (bus.LoadPat),
    .count (bus.MatchCount),
    .sat   (bus.CountSat)
  );

  assign bus.z        = z_q;
  assign bus.CurState = state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_detector -- directed vector bench; a CNT_W=8 and a CNT_W=2
// instance run on identical stimulus.
// Revision: 1.0
// ============================================================================
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) ifa ();
  seq_pattern_detector_if #(.PAT_W(4), .CNT_W(2)) ifb ();

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8)) dut_a (
    .Clock (clk),
    .Reset (Reset),
    .bus   (ifa.slave)
  );

  seq_pattern_detector #(.PAT_W(4), .CNT_W(2)) dut_b (
    .Clock (clk),
    .Reset (Reset),
    .bus   (ifb.slave)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] pat;
    logic       ovl;
    logic       v;
    logic       w;
    logic       ez;
    int         ecnt;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, input logic load, input logic [3:0] pat,
                              input logic ovl, input logic v, input logic w,
                              input logic ez, input int ecnt, input logic [1:0] est);
    vec_t t;
    t.rst = rst; t.load = load; t.pat = pat; t.ovl = ovl; t.v = v; t.w = w;
    t.ez = ez; t.ecnt = ecnt; t.est = est;
    vecs.push_back(t);
  endfunction

  task automatic apply(input logic rst, input logic load, input logic [3:0] pat,
                       input logic ovl, input logic v, input logic w);
    Reset        = rst;
    ifa.LoadPat  = load; ifa.PatIn = pat; ifa.Overlap = ovl; ifa.w_valid = v; ifa.w = w;
    ifb.LoadPat  = load; ifb.PatIn = pat; ifb.Overlap = ovl; ifb.w_valid = v; ifb.w = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int m;
    Reset = 1'b1;
    ifa.LoadPat = 1'b0; ifa.PatIn = '0; ifa.Overlap = 1'b0; ifa.w_valid = 1'b0; ifa.w = 1'b0;
    ifb.LoadPat = 1'b0; ifb.PatIn = '0; ifb.Overlap = 1'b0; ifb.w_valid = 1'b0; ifb.w = 1'b0;

    // Reset, then ones with no pattern loaded
    add(1, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    // 1101 single match
    add(0, 1, 4'b1101, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1, 1, 1, 2);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 1, 2);
    // 1111 overlapping, eight ones
    add(0, 1, 4'b1111, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++) add(0, 0, 4'h0, 1, 1, 1, 1, i, 2);
    // 1111 non-overlapping, eight ones
    add(0, 1, 4'b1111, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
    add(0, 0, 4'h0, 0, 1, 1, 1, 2, 1);
    // Gapped valid; invalid cycles carry contrary data
    add(0, 1, 4'b1101, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1, 2);
    add(0, 0, 4'h0, 1, 0, 0, 0, 1, 2);
    // Load mid-stream beats a concurrent valid bit
    add(0, 1, 4'b1101, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 4'b0110, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 2);
    // Reset mid-stream while z is high
    add(0, 1, 4'b1111, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1, 2);
    add(1, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 4'h0, 1, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].load, vecs[i].pat, vecs[i].ovl, vecs[i].v, vecs[i].w);
      chk($sformatf("v%0d z", i), int'(ifa.z), int'(vecs[i].ez));
      chk($sformatf("v%0d count", i), int'(ifa.MatchCount), vecs[i].ecnt);
      chk($sformatf("v%0d state", i), int'(ifa.CurState), int'(vecs[i].est));
      chk($sformatf("v%0d sat", i), int'(ifa.CountSat), 0);
      chk($sformatf("v%0d b_count", i), int'(ifb.MatchCount), (vecs[i].ecnt > 3) ? 3 : vecs[i].ecnt);
      chk($sformatf("v%0d b_sat", i), int'(ifb.CountSat), (vecs[i].ecnt >= 3) ? 1 : 0);
    end

    // Saturation of the 2-bit counter over ten ones
    apply(0, 1, 4'b1111, 1, 0, 0);
    chk("sat load b_count", int'(ifb.MatchCount), 0);
    chk("sat load b_sat", int'(ifb.CountSat), 0);
    for (int i = 1; i <= 10; i++) begin
      apply(0, 0, 4'h0, 1, 1, 1);
      m = (i >= 4) ? i - 3 : 0;
      chk($sformatf("sat%0d b_z", i), int'(ifb.z), (i >= 4) ? 1 : 0);
      chk($sformatf("sat%0d b_count", i), int'(ifb.MatchCount), (m > 3) ? 3 : m);
      chk($sformatf("sat%0d b_sat", i), int'(ifb.CountSat), (m >= 3) ? 1 : 0);
      chk($sformatf("sat%0d a_count", i), int'(ifa.MatchCount), m);
    end
    apply(0, 1, 4'b1111, 1, 1, 1);
    chk("reload b_count", int'(ifb.MatchCount), 0);
    chk("reload b_sat", int'(ifb.CountSat), 0);
    chk("reload b_state", int'(ifb.CurState), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial sequence detector that succeeds the fixed seven-state car-select FSM. Instead of a hard-coded state table, it takes a runtime-loadable PAT_W-bit pattern. It adds:
- a qualifying `w_valid` strobe,
- selectable overlapping or non-overlapping matching,
- a saturating match counter.

It sits between the debounced switch/serial input logic and the display/output logic. `z` drives the indicator LED and `CurState` drives the HEX state readout.

## Interface
- PAT_W, 4, pattern length in bits; legal 2..16
- CNT_W, 8, match counter width; legal 1..16
- Clock  input  1  rising-edge clock for all state
- Reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- LoadPat  input  1  load `PatIn` as the new pattern (one-cycle strobe)
- PatIn  input  PAT_W  pattern; bit PAT_W-1 is the first bit expected
- Overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match; sampled every cycle
- w_valid  input  1  qualifies `w`; bit accepted only when high
- w  input  1  serial data bit
- z  output  1  registered one-cycle match pulse
- MatchCount  output  CNT_W  number of matches since reset/load; saturating
- CountSat  output  1  sticky; set when MatchCount reaches all-ones
- CurState  output  2  FSM state encoding (IDLE=0, FILL=1, SEARCH=2)

## Operation
- Internal registers:
  - pattern register `pat_q` (PAT_W bits)
  - history shift register `hist_q` (PAT_W bits)
  - fill counter `fill_q` (0..PAT_W, $clog2(PAT_W+1) bits)
  - state register
- Accepted bit: `w_valid`=1 and state≠IDLE and `LoadPat`=0. On each accepted bit, `hist_q` shifts left with `w` entering the LSB, and `fill_q` increments (saturating at PAT_W).
- States:
  - IDLE: no pattern loaded; `w` ignored. `LoadPat` → FILL.
  - FILL: `fill_q`<PAT_W. When an accepted bit makes `fill_q`=PAT_W, compare; go to SEARCH, or stay in FILL on a non-overlap match (see below).
  - SEARCH: history full; compare on every accepted bit.
- Match: accepted bit and new history equals `pat_q` and new fill equals PAT_W.
  - Overlap=1: history is kept and state stays/goes SEARCH.
  - Overlap=0: `hist_q`, `fill_q` cleared; state is FILL.
- LoadPat, from any state:
  - `pat_q`←`PatIn`; `hist_q`, `fill_q`, MatchCount, CountSat cleared; state→FILL.
  - Concurrent `w` is discarded. LoadPat has priority over everything except Reset.
- MatchCount increments on each match and saturates at 2^CNT_W−1. CountSat is set in the same cycle MatchCount becomes all-ones and stays set until Reset/LoadPat.
- `w_valid`=0 cycles are invisible: no shift, no fill change, no state change, z=0.

## Timing
- Reset values: z=0, MatchCount=0, CountSat=0, CurState=IDLE, `pat_q`=0, `hist_q`=0, `fill_q`=0.
- Reset mid-sequence discards all history and the pattern; the block returns to IDLE. A new LoadPat is required.
- Latency: the final matching bit is accepted at edge N. z=1 and the updated MatchCount are visible after edge N, i.e. during cycle N+1. z is high for exactly one cycle per match.
- Back-to-back matches, possible only with Overlap=1 or PAT_W spacing, produce z high on consecutive cycles with no gap.
- CurState is updated at the same edge as the fill/history change.
- No combinational path from inputs to outputs.

## Structure
- Package `seq_det_pkg`: state enum (IDLE/FILL/SEARCH, 2-bit encoding) and `STATE_W`=2 localparam.
- Optional sub-module `sat_counter` holding MatchCount and CountSat, parameterised by CNT_W, with inc/clear inputs.
- Everything else is in one module: next-state always block plus a single synchronous register block.

## Test plan
- Reset, then 8 cycles with `w_valid`=1 and w=1, no LoadPat → z=0 throughout, CurState=0, MatchCount=0.
- LoadPat with PatIn=4'b1101, then stream 1,1,0,1 → z=1 exactly in the cycle after the 4th bit; MatchCount=1; CurState FILL→SEARCH.
- Pattern 4'b1111 with eight consecutive 1s:
  - Overlap=1 → z pulses after bits 4,5,6,7,8; MatchCount=5.
  - Overlap=0 → z pulses after bits 4 and 8; MatchCount=2.
- Pattern 1101 with `w_valid` toggled 1,0,1,0,... while w carries 1,x,1,x,0,x,1 → single match after the 4th valid bit; the x bits have no effect.
- CNT_W=2, Overlap=1, pattern 1111, ten 1s → MatchCount saturates at 3 after the 3rd match. CountSat=1 from that cycle; z still pulses on later matches.
- Mid-operation control:
  - After 3 bits 1,1,0 of pattern 1101, LoadPat with PatIn=4'b0110 and w_valid=1 in the same cycle → load wins; history cleared; the next 0,1,1,0 matches once.
  - Reset asserted mid-stream → all outputs return to reset values in the next cycle.
